// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU field widths, FSM states, opcodes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_share_pkg;

  // ALU field widths
  localparam int OPC_W = 3;
  localparam int OPD_W = 4;
  localparam int RES_W = 8;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes: 0..2 arithmetic, 3..7 comparison
  localparam logic [OPC_W-1:0] OPC_ADD = 3'd0;
  localparam logic [OPC_W-1:0] OPC_SUB = 3'd1;
  localparam logic [OPC_W-1:0] OPC_MUL = 3'd2;
  localparam logic [OPC_W-1:0] OPC_EQ  = 3'd3;
  localparam logic [OPC_W-1:0] OPC_NE  = 3'd4;
  localparam logic [OPC_W-1:0] OPC_LT  = 3'd5;
  localparam logic [OPC_W-1:0] OPC_GT  = 3'd6;
  localparam logic [OPC_W-1:0] OPC_LE  = 3'd7;

  function automatic logic is_cmp_opc(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_EQ);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational winner selection: one-hot grant plus its index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant is a pure function of valid (and last in round-robin mode).
//
// Ports:
//   valid    in   NUM_REQ  request valids
//   last     in   ID_W     previous winner (round-robin build only)
//   grant    out  NUM_REQ  one-hot winner, 0 when no valid
//   grant_id out  ID_W     index of the winner, 0 when no valid
// Macro ALU_SHARE_FIXED_PRIO_EN: lowest valid index wins and the last input is removed.
module rr_pick
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
`ifndef ALU_SHARE_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    last,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic found;

`ifdef ALU_SHARE_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end
`else
  // Two ascending passes give the wrap-around search without a modulo:
  // first the indices above last, then the indices up to and including last.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (i > int'(last))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && valid[i] && (i <= int'(last))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered 4-bit ALU among NUM_REQ requesters, returning id-tagged results.
// Latency: resp_valid rises ALU_LAT+1 edges after the accept edge; one op per ALU_LAT+3 cycles at best.
// Backpressure: result held in RESP until resp_ready; no new request is accepted outside IDLE.
//
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   req_valid/req_ready        per-requester handshake; req_ready is a one-hot accept strobe
//   req_opc/req_a/req_b        packed per-requester opcode/operands (requester i at slot i)
//   alu_opc/alu_a/alu_b/alu_c  registered operands to the ALU and its result
//   resp_valid/resp_ready      result handshake; resp_id/resp_data carry owner and result
//   busy                       high whenever the FSM is not IDLE
// Macro ALU_SHARE_FIXED_PRIO_EN: fixed-priority arbitration (lowest index), no rr pointer.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [OPC_W*NUM_REQ-1:0]   req_opc,
  input  logic [OPD_W*NUM_REQ-1:0]   req_a,
  input  logic [OPD_W*NUM_REQ-1:0]   req_b,
  output logic [OPC_W-1:0]           alu_opc,
  output logic [OPD_W-1:0]           alu_a,
  output logic [OPD_W-1:0]           alu_b,
  input  logic [RES_W-1:0]           alu_c,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [RES_W-1:0]           resp_data,
  output logic                       busy
);

  localparam int CNT_W = 3;  // ALU_LAT is at most 7

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               accept;
  logic [OPC_W-1:0]   sel_opc;
  logic [OPD_W-1:0]   sel_a;
  logic [OPD_W-1:0]   sel_b;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic [ID_W-1:0]    last;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid    (req_valid),
`ifndef ALU_SHARE_FIXED_PRIO_EN
    .last     (last),
`endif
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant is only visible in IDLE and is masked during reset so req_ready reads 0 there.
  assign req_ready = ((state == IDLE) && !rst) ? grant : '0;
  assign accept    = |req_ready;
  assign busy      = (state != IDLE);

  // One-hot mux of the winner's opcode and operands
  always_comb begin
    sel_opc = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_opc = req_opc[i*OPC_W +: OPC_W];
        sel_a   = req_a[i*OPD_W +: OPD_W];
        sel_b   = req_b[i*OPD_W +: OPD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)     state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand, latency counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opc    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_opc <= sel_opc;
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            resp_id <= grant_id;
            cnt     <= CNT_W'(ALU_LAT);
          end
        end
        WAIT: begin
          // alu_* stay untouched so the ALU sees stable inputs for the whole wait
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_data  <= alu_c;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // Pointer resets to the top index so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      last <= grant_id;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 1;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_opc;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [2:0]     alu_opc;
  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic [7:0]     alu_c;
  logic           resp_valid;
  logic           resp_ready;
  logic [IDW-1:0] resp_id;
  logic [7:0]     resp_data;
  logic           busy;

  int n_chk  = 0;
  int n_fail = 0;

  // Scoreboard and reference model state
  exp_t       exp_q[$];
  int         m_state;   // 0 idle, 1 waiting on ALU, 2 result offered
  int         m_last;
  int         m_k;
  logic [2:0] m_opc;
  logic [3:0] m_a;
  logic [3:0] m_b;

  // Stimulus bookkeeping
  int         policy;    // 0 no new requests, 1 re-raise every requester, 2 random
  logic       allow_drop;
  int         cyc;
  int         acc_log[$];
  int         acc_cyc[$];

  alu_share_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IDW),
    .ALU_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opc    (req_opc),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_opc    (alu_opc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  // ALU stub: LAT-stage register pipeline producing {a,b}
  logic [7:0] alu_pipe [LAT];
  always_ff @(posedge clk) begin
    alu_pipe[0] <= {alu_a, alu_b};
    for (int k = 1; k < LAT; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_c = alu_pipe[LAT-1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v, input int last);
    int j;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  // Reference model: requests are taken only when idle, the result appears
  // LAT+1 edges after the accept and stays until a resp_ready edge.
  initial begin
    int   w;
    exp_t e;
    m_state = 0;
    m_last  = N - 1;
    m_k     = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        m_state = 0;
        m_last  = N - 1;
      end else begin
        case (m_state)
          0: begin
            w = model_pick(req_valid, m_last);
            if (w >= 0) begin
              e.id   = w;
              e.data = {req_a[4*w +: 4], req_b[4*w +: 4]};
              exp_q.push_back(e);
              m_opc   = req_opc[3*w +: 3];
              m_a     = req_a[4*w +: 4];
              m_b     = req_b[4*w +: 4];
              m_last  = w;
              m_k     = 0;
              m_state = 1;
            end
          end
          1: begin
            m_k++;
            if (m_k == LAT + 1) m_state = 2;
          end
          default: if (resp_ready) m_state = 0;
        endcase
      end
    end
  end

  // Monitor: compares outputs against the model every negedge and pops results on transfer
  initial begin
    int         w;
    logic [N-1:0] exp_rdy;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
      end else begin
        w = model_pick(req_valid, m_last);
        exp_rdy = (m_state == 0 && w >= 0) ? N'(1) << w : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, m_state != 0);
        chk("resp_valid", resp_valid, m_state == 2);
        if (m_state != 0) begin
          chk("alu_operands", {alu_opc, alu_a, alu_b}, {m_opc, m_a, m_b});
        end
        if (resp_valid && resp_ready) begin
          chk("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_id", resp_id, e.id);
            chk("resp_data", resp_data, e.data);
          end
        end
      end
    end
  end

  task automatic raise(input int i, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    req_valid[i]        = 1'b1;
    req_opc[3*i +: 3]   = o;
    req_a[4*i +: 4]     = a;
    req_b[4*i +: 4]     = b;
  endtask

  // One clock: note accepts at the negedge, then update inputs just after the posedge
  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready & {N{~rst}};
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc_log.push_back(i);
        acc_cyc.push_back(cyc);
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && (policy == 1 || (policy == 2 && $urandom_range(0, 3) == 0))) begin
        if (policy == 1) raise(i, 3'(i), 4'(i), 4'(i));
        else raise(i, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end else if (req_valid[i] && !acc[i] && policy == 2 && allow_drop && $urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
    if (policy == 2) resp_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic wait_accept(input string name, input int limit);
    int base;
    int n;
    base = acc_log.size();
    n = 0;
    while (acc_log.size() == base && n < limit) begin
      cycle();
      n++;
    end
    chk(name, acc_log.size() > base, 1);
  endtask

  task automatic drain(input string name);
    int n;
    policy = 0;
    resp_ready = 1'b1;
    n = 0;
    while ((req_valid != '0 || busy) && n < 300) begin
      cycle();
      n++;
    end
    chk(name, (req_valid == '0) && !busy, 1);
  endtask

  initial begin
    int exp_seq[5];
    rst = 1'b1;
    req_valid = '0;
    req_opc = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    policy = 0;
    allow_drop = 1'b0;
    cyc = 0;

    // Reset state, with some valids raised to confirm req_ready stays low
    req_valid = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, resp_valid, resp_id, resp_data, busy, alu_opc, alu_a, alu_b}, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request: latency and data
    resp_ready = 1'b1;
    raise(0, 3'd0, 4'd3, 4'd4);
    wait_accept("single_accept_timeout", 20);
    #1;
    chk("single_alu_operands", {alu_opc, alu_a, alu_b}, {3'd0, 4'd3, 4'd4});
    for (int k = 0; k < LAT; k++) begin
      cycle();
      #1;
      chk("single_resp_early", resp_valid, 0);
    end
    cycle();
    #1;
    chk("single_resp_valid", resp_valid, 1);
    chk("single_resp", {resp_id, resp_data}, {2'd0, 8'h34});
    drain("single_drain");

    // Rotation from a fresh pointer with all requesters valid
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    acc_log.delete();
    acc_cyc.delete();
    policy = 1;
    for (int i = 0; i < N; i++) raise(i, 3'(i), 4'(i), 4'(i));
    for (int g = 0; g < 5; g++) wait_accept("rot_accept_timeout", 20);
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    for (int g = 0; g < 5; g++) begin
      if (acc_log.size() > g) chk("rot_grant", acc_log[g], exp_seq[g]);
      else chk("rot_grant_missing", acc_log.size(), 5);
      if (g > 0 && acc_cyc.size() > g) chk("rot_spacing", acc_cyc[g] - acc_cyc[g-1], LAT + 3);
    end
    drain("rot_drain");

    // Backpressure: hold the result for 5 cycles with another request pending
    resp_ready = 1'b0;
    raise(1, 3'd5, 4'hA, 4'h6);
    wait_accept("bp_accept_timeout", 20);
    raise(0, 3'd2, 4'h1, 4'h2);
    for (int k = 0; k <= LAT; k++) cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_busy", busy, 1);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_result", {resp_id, resp_data}, {2'd1, 8'hA6});
      cycle();
    end
    resp_ready = 1'b1;
    cycle();
    #1;
    chk("bp_release_busy", busy, 0);
    drain("bp_drain");

    // Reset in WAIT discards the operation and restores the pointer
    raise(2, 3'd4, 4'h7, 4'h9);
    wait_accept("rstw_accept_timeout", 20);
    #1;
    chk("rstw_in_wait", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstw_outputs", {req_ready, resp_valid, resp_id, resp_data, busy, alu_opc, alu_a, alu_b}, 0);
    cycle();
    rst = 1'b0;
    acc_log.delete();
    for (int i = 0; i < N; i++) raise(i, 3'(i), 4'(N - i), 4'(i));
    wait_accept("rstw_next_timeout", 20);
    if (acc_log.size() > 0) chk("rstw_next_grant", acc_log[0], 0);
    drain("rstw_drain");

    // Randomized traffic with drops and random resp_ready
    policy = 2;
    allow_drop = 1'b1;
    repeat (1500) cycle();
    allow_drop = 1'b0;
    drain("rand_drain");
    repeat (3) cycle();
    chk("sb_empty_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
